// File: rtl/gpio_cmd_sequencer.sv
// GPIO-driven command sequencer for an image RAM and a convolution engine.
// A micro writes a command word on i_gpo and reads the response on o_gpi with a
// four-phase handshake on bit [31] (enable out, ack back).
//
// Ports:
//   clock, i_reset   - rising-edge clock, asynchronous active-low reset
//   i_gpo            - command: [31] enable, [30:24] opcode, [23:0] data
//   o_gpi            - response: [31] ack, [30:24] echoed opcode, [23:0] result
//   o_ram_we/addr/wdata, i_ram_rdata - image RAM port (read data one cycle late)
//   o_conv_start, i_conv_done        - convolution engine start pulse / done
module gpio_cmd_sequencer #(
    parameter int unsigned NB_GPIOS     = 32,
    parameter int unsigned NB_C0M       = 7,
    parameter int unsigned NB_DATA      = 24,
    parameter int unsigned RAM_WIDTH    = 8,
    parameter int unsigned RAM_DEPTH    = 2**16,
    parameter int unsigned CONV_TIMEOUT = 4096
) (
    input  logic                         clock,
    input  logic                         i_reset,
    input  logic [NB_GPIOS-1:0]          i_gpo,
    output logic [NB_GPIOS-1:0]          o_gpi,
    output logic                         o_ram_we,
    output logic [$clog2(RAM_DEPTH)-1:0] o_ram_addr,
    output logic [RAM_WIDTH-1:0]         o_ram_wdata,
    input  logic [RAM_WIDTH-1:0]         i_ram_rdata,
    output logic                         o_conv_start,
    input  logic                         i_conv_done
);
    localparam int unsigned NA   = $clog2(RAM_DEPTH);
    localparam int unsigned CntW = $clog2(CONV_TIMEOUT + 1);

    localparam logic [NA-1:0]     LastAddr = NA'(RAM_DEPTH - 1);
    localparam logic [CntW-1:0]   LastCnt  = CntW'(CONV_TIMEOUT - 1);

    localparam logic [NB_C0M-1:0] OpRstPtr    = NB_C0M'(1);
    localparam logic [NB_C0M-1:0] OpWrPix     = NB_C0M'(2);
    localparam logic [NB_C0M-1:0] OpStartConv = NB_C0M'(3);
    localparam logic [NB_C0M-1:0] OpRdPix     = NB_C0M'(4);
    localparam logic [NB_C0M-1:0] OpRdStatus  = NB_C0M'(5);

    typedef enum logic [2:0] {StIdle, StExec, StRdWait, StConvBusy, StAck} state_e;

    state_e state_q, state_d;

    logic en_q1, en_q2, en_q3;
    logic en_rise;

    logic [NB_C0M-1:0]    op_q;
    logic [RAM_WIDTH-1:0] pix_q;
    logic [NB_DATA-1:0]   result_q;
    logic [NA-1:0]        wr_ptr_q, rd_ptr_q, wr_ptr_nxt, rd_ptr_nxt;
    logic [CntW-1:0]      cnt_q;
    logic                 ovf_q, timeout_q, bad_q, done_q;
    logic [15:0]          wp16;
    logic [NB_DATA-1:0]   status;
    logic                 unused_gpo;

    // Data bits above the pixel field are carried by the command word but unused.
    assign unused_gpo = ^i_gpo[NB_DATA-1:RAM_WIDTH];

    assign en_rise    = en_q2 & ~en_q3;
    assign wr_ptr_nxt = (wr_ptr_q == LastAddr) ? '0 : wr_ptr_q + 1'b1;
    assign rd_ptr_nxt = (rd_ptr_q == LastAddr) ? '0 : rd_ptr_q + 1'b1;
    assign wp16       = 16'(wr_ptr_q);
    assign status     = NB_DATA'({wp16, 4'b0000, ovf_q, timeout_q, bad_q, done_q});

    // Enable sync/edge flops reset to 1 so an enable held high across reset
    // release is not mistaken for a new command.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            en_q1 <= 1'b1;
            en_q2 <= 1'b1;
            en_q3 <= 1'b1;
        end else begin
            en_q1 <= i_gpo[NB_GPIOS-1];
            en_q2 <= en_q1;
            en_q3 <= en_q2;
        end
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (en_rise) state_d = StExec;
            StExec: begin
                if (op_q == OpStartConv) begin
                    state_d = StConvBusy;
                end else if (op_q == OpRdPix) begin
                    state_d = StRdWait;
                end else begin
                    state_d = StAck;
                end
            end
            StRdWait:   state_d = StAck;
            StConvBusy: if (i_conv_done || (cnt_q == LastCnt)) state_d = StAck;
            StAck:      if (!en_q2) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        o_ram_we     = 1'b0;
        o_ram_addr   = '0;
        o_ram_wdata  = '0;
        o_conv_start = 1'b0;
        o_gpi        = '0;
        unique case (state_q)
            StExec: begin
                if (op_q == OpWrPix) begin
                    o_ram_we    = 1'b1;
                    o_ram_addr  = wr_ptr_q;
                    o_ram_wdata = pix_q;
                end else if (op_q == OpRdPix) begin
                    o_ram_addr  = rd_ptr_q;
                end else if (op_q == OpStartConv) begin
                    o_conv_start = 1'b1;
                end
            end
            StAck:   o_gpi = NB_GPIOS'({1'b1, op_q, result_q});
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            op_q      <= '0;
            pix_q     <= '0;
            result_q  <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            timeout_q <= 1'b0;
            bad_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (en_rise) begin
                        op_q     <= i_gpo[NB_DATA +: NB_C0M];
                        pix_q    <= i_gpo[RAM_WIDTH-1:0];
                        result_q <= '0;
                    end
                end
                StExec: begin
                    cnt_q <= '0;
                    case (op_q)
                        OpRstPtr: begin
                            wr_ptr_q  <= '0;
                            rd_ptr_q  <= '0;
                            ovf_q     <= 1'b0;
                            timeout_q <= 1'b0;
                            bad_q     <= 1'b0;
                            done_q    <= 1'b0;
                        end
                        OpWrPix: begin
                            wr_ptr_q <= wr_ptr_nxt;
                            if (wr_ptr_q == LastAddr) ovf_q <= 1'b1;
                        end
                        OpRdStatus:           result_q <= status;
                        OpStartConv, OpRdPix: begin end
                        default:              bad_q <= 1'b1;
                    endcase
                end
                StRdWait: begin
                    result_q <= NB_DATA'(i_ram_rdata);
                    rd_ptr_q <= rd_ptr_nxt;
                end
                StConvBusy: begin
                    if (i_conv_done) begin
                        done_q <= 1'b1;
                    end else if (cnt_q == LastCnt) begin
                        timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
